// File: rtl/exp_golomb_k_coder.sv
// Order-k Exp-Golomb serial encoder: one symbol in, codeword out MSB-first with last flag and length sideband.
// Latency: the first code bit is valid the cycle after accept. The accept cycle is not overlapped, so a codeword takes len+1 cycles.
// Backpressure: ready_o only in IDLE; out_ready_i low freezes dt_o/last_o/len_o, state and counters.
module exp_golomb_k_coder #(
  parameter int DATA_WIDTH = 8,
  parameter int K_MAX      = 4,
  parameter int K_WIDTH    = 3,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  dft_tm_i,
  input  logic [DATA_WIDTH-1:0] dt_i,
  input  logic [K_WIDTH-1:0]    k_i,
  input  logic                  signed_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  dt_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [LEN_WIDTH-1:0]  len_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  localparam int IW = DATA_WIDTH + 2;
  localparam int NW = $clog2(IW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2
  } state_t;

  logic                 rstn_b_w;
  state_t               state_q;
  logic [IW-1:0]        y_q;
  logic [NW-1:0]        z_q;
  logic [NW-1:0]        idx_q;
  logic                 dt_q;
  logic                 vld_q;
  logic                 last_q;
  logic [LEN_WIDTH-1:0] len_q;

  logic [K_WIDTH-1:0]   k_c;
  logic [IW-1:0]        vd_c;
  logic [IW-1:0]        m_c;
  logic [IW-1:0]        y_c;
  logic [NW-1:0]        n_c;
  logic [NW-1:0]        z_c;
  logic [LEN_WIDTH-1:0] len_c;

  assign rstn_b_w = dft_tm_i ? 1'b1 : rstn_i;

  // vd_c is the sign-extended symbol times two; the signed map is 2v-1 for v>0, else -2v.
  always_comb begin
    k_c  = (k_i > K_WIDTH'(K_MAX)) ? K_WIDTH'(K_MAX) : k_i;
    vd_c = {dt_i[DATA_WIDTH-1], dt_i, 1'b0};
    m_c  = {2'b00, dt_i};
    if (signed_i) begin
      if (!dt_i[DATA_WIDTH-1] && (|dt_i)) m_c = vd_c - IW'(1);
      else                                m_c = '0 - vd_c;
    end
    y_c = m_c + (IW'(1) << k_c);
    n_c = '0;
    for (int i = 0; i < IW; i++) begin
      if (y_c[i]) n_c = NW'(i);
    end
    z_c   = n_c - NW'(k_c);
    len_c = LEN_WIDTH'({n_c, 1'b0}) - LEN_WIDTH'(k_c) + LEN_WIDTH'(1);
  end

  // Outputs are registered: each transition also loads the bit that the next state presents.
  always_ff @(posedge clk_i or negedge rstn_b_w) begin
    if (!rstn_b_w) begin
      state_q <= IDLE;
      y_q     <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      dt_q    <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            y_q   <= y_c;
            idx_q <= n_c;
            len_q <= len_c;
            vld_q <= 1'b1;
            if (z_c != '0) begin
              state_q <= PREFIX;
              z_q     <= z_c;
              dt_q    <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              state_q <= SUFFIX;
              z_q     <= '0;
              dt_q    <= y_c[n_c];
              last_q  <= (n_c == '0);
            end
          end
        end
        PREFIX: begin
          if (out_ready_i) begin
            if (z_q == NW'(1)) begin
              state_q <= SUFFIX;
              z_q     <= '0;
              dt_q    <= y_q[idx_q];
              last_q  <= (idx_q == '0);
            end else begin
              z_q <= z_q - NW'(1);
            end
          end
        end
        SUFFIX: begin
          if (out_ready_i) begin
            if (idx_q == '0) begin
              state_q <= IDLE;
              vld_q   <= 1'b0;
              dt_q    <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q  <= idx_q - NW'(1);
              dt_q   <= y_q[idx_q - NW'(1)];
              last_q <= (idx_q == NW'(1));
            end
          end
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          dt_q    <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q != IDLE);
  assign dt_o    = dt_q;
  assign valid_o = vld_q;
  assign last_o  = last_q;
  assign len_o   = len_q;

endmodule

// File: tb/tb_exp_golomb_k_coder.sv
// Randomised and directed bench for exp_golomb_k_coder against an arithmetic Exp-Golomb model.
module tb_exp_golomb_k_coder;

  localparam int DW   = 8;
  localparam int KMAX = 4;

  logic       clk_i = 1'b0;
  logic       rstn_i, dft_tm_i;
  logic [7:0] dt_i;
  logic [2:0] k_i;
  logic       signed_i, valid_i, ready_o, dt_o, valid_o, last_o, out_ready_i, busy_o;
  logic [4:0] len_o;

  exp_golomb_k_coder #(.DATA_WIDTH(8), .K_MAX(4), .K_WIDTH(3), .LEN_WIDTH(5)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .dft_tm_i(dft_tm_i), .dt_i(dt_i), .k_i(k_i),
    .signed_i(signed_i), .valid_i(valid_i), .ready_o(ready_o), .dt_o(dt_o),
    .valid_o(valid_o), .last_o(last_o), .len_o(len_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {bit b; bit l; int len;} ebit_t;
  ebit_t sb[$];
  int    vecs = 0, errs = 0, xfers = 0, orm = 0;

  function automatic void cmp(string nm, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Codeword value is y itself (leading zeros are implicit in the length).
  function automatic void model(input int dt, input int k, input bit s, output int len, output int val);
    int v, m, kk, y, n;
    if (s) begin
      v = (dt >= 2**(DW-1)) ? dt - 2**DW : dt;
      m = (v > 0) ? 2*v - 1 : -2*v;
    end else m = dt;
    kk = (k > KMAX) ? KMAX : k;
    y  = m + (1 << kk);
    n  = 0;
    while ((y >> (n+1)) != 0) n++;
    len = 2*n - kk + 1;
    val = y;
  endfunction

  function automatic void pin(string nm, int dt, int k, bit s, int elen, int eval);
    int l, v;
    model(dt, k, s, l, v);
    cmp({nm, "_len"}, l, elen);
    cmp({nm, "_val"}, v, eval);
  endfunction

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (orm)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 3) != 0);
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  bit         exp_first = 0, exp_gap = 0, stall_prev = 0;
  logic       pv, pd, pl;
  logic [4:0] plen;

  always @(negedge clk_i) begin
    if (!(dft_tm_i || rstn_i)) begin
      exp_first = 0; exp_gap = 0; stall_prev = 0;
    end else begin
      if (stall_prev) begin
        cmp("hold_valid", int'(valid_o), int'(pv));
        cmp("hold_dt", int'(dt_o), int'(pd));
        cmp("hold_last", int'(last_o), int'(pl));
        cmp("hold_len", int'(len_o), int'(plen));
      end
      if (exp_first) begin
        cmp("first_bit_latency", int'(valid_o), 1);
        cmp("ready_after_accept", int'(ready_o), 0);
      end
      if (exp_gap) begin
        cmp("gap_valid", int'(valid_o), 0);
        cmp("gap_ready", int'(ready_o), 1);
      end
      cmp("busy_vs_ready", int'(busy_o), int'(!ready_o));
      if (valid_o) begin
        if (sb.size() == 0) cmp("spurious_valid", int'(valid_o), 0);
        else begin
          cmp("dt", int'(dt_o), int'(sb[0].b));
          cmp("last", int'(last_o), int'(sb[0].l));
          cmp("len", int'(len_o), sb[0].len);
          if (out_ready_i) begin
            void'(sb.pop_front());
            xfers++;
          end
        end
      end else begin
        cmp("idle_dt", int'(dt_o), 0);
        cmp("idle_last", int'(last_o), 0);
      end
      stall_prev = valid_o && !out_ready_i;
      pv = valid_o; pd = dt_o; pl = last_o; plen = len_o;
      exp_gap   = valid_o && out_ready_i && last_o;
      exp_first = valid_i && ready_o;
      if (exp_first) begin
        int l, v;
        model(int'(dt_i), int'(k_i), signed_i, l, v);
        for (int i = l - 1; i >= 0; i--) sb.push_back('{b: ((v >> i) & 1) != 0, l: (i == 0), len: l});
      end
    end
  end

  task automatic send(input int dt, input int k, input bit s, input bit hold);
    bit acc;
    dt_i = 8'(dt); k_i = 3'(k); signed_i = s; valid_i = 1'b1;
    acc = 0;
    for (int c = 0; c < 400 && !acc; c++) begin
      @(negedge clk_i); acc = ready_o;
      @(posedge clk_i); #1;
    end
    if (!acc) cmp("accept_timeout", 0, 1);
    if (!hold) valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (sb.size() == 0 && ready_o && !valid_i) done = 1;
      else begin @(posedge clk_i); #1; end
    end
    if (!done) cmp("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int dir_tab[10][3] = '{'{0,0,0}, '{4,0,0}, '{3,2,0}, '{9,2,0}, '{3,7,0},
                         '{1,0,1}, '{254,0,1}, '{0,0,1}, '{128,0,1}, '{255,0,0}};

  initial begin
    int x0;
    rstn_i = 1'b0; dft_tm_i = 1'b0; valid_i = 1'b0; dt_i = '0; k_i = '0; signed_i = 1'b0;
    #12;
    cmp("rst_valid", int'(valid_o), 0);
    cmp("rst_dt", int'(dt_o), 0);
    cmp("rst_last", int'(last_o), 0);
    cmp("rst_busy", int'(busy_o), 0);
    cmp("rst_len", int'(len_o), 0);
    cmp("rst_ready", int'(ready_o), 1);

    pin("u_k0_0", 0, 0, 0, 1, 1);
    pin("u_k0_4", 4, 0, 0, 5, 5);
    pin("u_k2_3", 3, 2, 0, 3, 7);
    pin("u_k2_9", 9, 2, 0, 5, 13);
    pin("u_k7_clamp", 3, 7, 0, 5, 19);
    pin("s_p1", 1, 0, 1, 3, 2);
    pin("s_m2", 254, 0, 1, 5, 5);
    pin("s_0", 0, 0, 1, 1, 1);
    pin("s_min", 128, 0, 1, 17, 257);
    pin("u_255", 255, 0, 0, 17, 256);

    @(posedge clk_i); #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    foreach (dir_tab[i]) begin
      send(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2] != 0, 0);
      drain();
    end

    // Stall inside the prefix of the 17-bit codeword for 255.
    x0 = xfers;
    send(255, 0, 0, 0);
    @(posedge clk_i); #1 orm = 2;
    repeat (3) @(posedge clk_i);
    #1 orm = 0;
    drain();
    cmp("stall_xfers", xfers - x0, 17);

    send(1, 0, 0, 1);
    send(2, 1, 0, 1);
    send(254, 2, 1, 0);
    drain();

    send(255, 0, 0, 0);
    repeat (10) @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    cmp("midrst_valid", int'(valid_o), 0);
    cmp("midrst_ready", int'(ready_o), 1);
    cmp("midrst_len", int'(len_o), 0);
    cmp("midrst_busy", int'(busy_o), 0);
    sb.delete();
    @(posedge clk_i); #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    send(4, 0, 0, 0);
    drain();

    dft_tm_i = 1'b1;
    send(255, 0, 0, 0);
    repeat (5) @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1 cmp("dft_mask_valid", int'(valid_o), 1);
    @(posedge clk_i); #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    drain();
    dft_tm_i = 1'b0;

    orm = 1;
    for (int i = 0; i < 150; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) begin @(posedge clk_i); #1; end
    end
    valid_i = 1'b0;
    drain();
    orm = 0;
    cmp("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
